// File: rtl/axi4_chk_pkg.sv
// Shared types and constants for the AXI4 write-path protocol checker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi4_chk_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } burst_e;

    // Bit positions inside the error vector
    localparam int ERR_AW_OVF      = 0;
    localparam int ERR_W_NO_AW     = 1;
    localparam int ERR_WLAST_EARLY = 2;
    localparam int ERR_WLAST_MISS  = 3;
    localparam int ERR_B_UNEXP     = 4;
    localparam int ERR_BURST       = 5;
    localparam int ERR_SIZE        = 6;
    localparam int ERR_STAB        = 7;

    typedef logic [7:0] err_vec_t;

    // An INCR burst may end exactly on this boundary but not cross it
    localparam logic [16:0] BOUNDARY_4KB = 17'd4096;

endpackage

// File: rtl/axi4_chk_fifo.sv
// Synchronous FIFO holding accepted AW entries awaiting their W data.
// Latency: pushed entry visible at dout the cycle after push (head is combinational from storage).
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module axi4_chk_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi4_wr_protocol_checker.sv
// Passive AXI4 write-channel checker: burst legality, W beat counting, B response debt per ID.
// Latency: every error flag and pulse is registered, visible 1 cycle after the offending handshake.
// Backpressure: none exerted; only observes handshakes. Optional macro AXI_STABILITY_CHK_EN adds VALID/payload stability checks.
module axi4_wr_protocol_checker
    import axi4_chk_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int LEN_WIDTH       = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               AWCLK,
    input  logic                               ARESETn,
    input  logic                               AWVALID,
    input  logic                               AWREADY,
    input  logic [ADDR_WIDTH-1:0]              AWADDR,
    input  logic [ID_WIDTH-1:0]                AWID,
    input  logic [LEN_WIDTH-1:0]               AWLEN,
    input  logic [2:0]                         AWSIZE,
    input  logic [1:0]                         AWBURST,
    input  logic                               WVALID,
    input  logic                               WREADY,
    input  logic                               WLAST,
    input  logic [DATA_WIDTH-1:0]              WDATA,
    input  logic [DATA_WIDTH/8-1:0]            WSTRB,
    input  logic                               BVALID,
    input  logic                               BREADY,
    input  logic [ID_WIDTH-1:0]                BID,
    input  logic [1:0]                         BRESP,
    input  logic                               err_clr,
    output err_vec_t                           err_flags,
    output logic                               err_pulse,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
    output logic [LEN_WIDTH:0]                 wbeat_cnt
);

    localparam int            CNT_W    = $clog2(MAX_OUTSTANDING+1);
    localparam int            FIFO_W   = ID_WIDTH + LEN_WIDTH;
    localparam int            NUM_IDS  = 1 << ID_WIDTH;
    localparam logic [2:0]    SIZE_MAX = 3'($clog2(DATA_WIDTH/8));

    logic                 aw_hs, w_hs, b_hs;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FIFO_W-1:0]    fifo_dout;
    logic [ID_WIDTH-1:0]  head_id;
    logic [LEN_WIDTH-1:0] head_len;
    logic                 w_has_head, w_bypass, beat_is_len, burst_end;
    logic [16:0]          incr_end;
    logic                 wrap_len_ok;
    burst_e               aw_burst;
    logic                 stab_err;
    err_vec_t             new_err;
    logic [CNT_W-1:0]     pending [NUM_IDS];
    logic [NUM_IDS-1:0]   pend_inc, pend_dec;
    logic                 unused_sig;

    assign aw_hs    = AWVALID & AWREADY;
    assign w_hs     = WVALID & WREADY;
    assign b_hs     = BVALID & BREADY;
    assign aw_burst = burst_e'(AWBURST);

    // With an empty FIFO, a same-cycle AW serves as the head burst
    assign {head_id, head_len} = fifo_empty ? {AWID, AWLEN} : fifo_dout;
    assign w_has_head  = w_hs & (~fifo_empty | aw_hs);
    assign w_bypass    = w_hs & fifo_empty & aw_hs;
    assign beat_is_len = (wbeat_cnt == {1'b0, head_len});
    assign burst_end   = w_has_head & (WLAST | beat_is_len);
    assign fifo_pop    = burst_end & ~fifo_empty;
    // A bypassed burst that also finishes this cycle never needs storing
    assign fifo_push   = aw_hs & ~(w_bypass & burst_end);

    axi4_chk_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk   (AWCLK),
        .rst_n (ARESETn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({AWID, AWLEN}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding_cnt)
    );

    assign incr_end = {5'd0, AWADDR[11:0]} + ((17'(AWLEN) + 17'd1) << AWSIZE);
    assign wrap_len_ok = (AWLEN == LEN_WIDTH'(1)) | (AWLEN == LEN_WIDTH'(3)) |
                         (AWLEN == LEN_WIDTH'(7)) | (AWLEN == LEN_WIDTH'(15));

`ifdef AXI_STABILITY_CHK_EN
    localparam int AW_PAY_W = ADDR_WIDTH + ID_WIDTH + LEN_WIDTH + 5;
    localparam int W_PAY_W  = DATA_WIDTH + DATA_WIDTH/8 + 1;
    localparam int B_PAY_W  = ID_WIDTH + 2;

    logic [AW_PAY_W-1:0] aw_pay, aw_pay_q;
    logic [W_PAY_W-1:0]  w_pay, w_pay_q;
    logic [B_PAY_W-1:0]  b_pay, b_pay_q;
    logic                aw_stall_q, w_stall_q, b_stall_q;

    assign aw_pay = {AWADDR, AWID, AWLEN, AWSIZE, AWBURST};
    assign w_pay  = {WDATA, WSTRB, WLAST};
    assign b_pay  = {BID, BRESP};

    // Remember which channels were stalled last cycle and what they carried
    always_ff @(posedge AWCLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_stall_q <= 1'b0;
            w_stall_q  <= 1'b0;
            b_stall_q  <= 1'b0;
            aw_pay_q   <= '0;
            w_pay_q    <= '0;
            b_pay_q    <= '0;
        end else begin
            aw_stall_q <= AWVALID & ~AWREADY;
            w_stall_q  <= WVALID & ~WREADY;
            b_stall_q  <= BVALID & ~BREADY;
            aw_pay_q   <= aw_pay;
            w_pay_q    <= w_pay;
            b_pay_q    <= b_pay;
        end
    end

    assign stab_err = (aw_stall_q & (~AWVALID | (aw_pay != aw_pay_q))) |
                      (w_stall_q  & (~WVALID  | (w_pay  != w_pay_q)))  |
                      (b_stall_q  & (~BVALID  | (b_pay  != b_pay_q)));
`else
    assign stab_err = 1'b0;
`endif

    // Collect every violation seen this cycle
    always_comb begin
        new_err                  = '0;
        new_err[ERR_AW_OVF]      = aw_hs & fifo_full & ~fifo_pop;
        new_err[ERR_W_NO_AW]     = w_hs & fifo_empty & ~aw_hs;
        new_err[ERR_WLAST_EARLY] = w_has_head & WLAST & (wbeat_cnt < {1'b0, head_len});
        new_err[ERR_WLAST_MISS]  = w_has_head & ~WLAST & beat_is_len;
        new_err[ERR_B_UNEXP]     = b_hs & (pending[BID] == '0);
        new_err[ERR_BURST]       = aw_hs & ((aw_burst == RSVD) |
                                            ((aw_burst == WRAP) & ~wrap_len_ok) |
                                            ((aw_burst == INCR) & (incr_end > BOUNDARY_4KB)));
        new_err[ERR_SIZE]        = aw_hs & (AWSIZE > SIZE_MAX);
        new_err[ERR_STAB]        = stab_err;
    end

    // Sticky flags; errors arriving with a clear are kept
    always_ff @(posedge AWCLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_flags <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_flags <= err_clr ? new_err : (err_flags | new_err);
            err_pulse <= |new_err;
        end
    end

    // Beat index within the current W burst
    always_ff @(posedge AWCLK or negedge ARESETn) begin
        if (!ARESETn)        wbeat_cnt <= '0;
        else if (burst_end)  wbeat_cnt <= '0;
        else if (w_has_head) wbeat_cnt <= wbeat_cnt + (LEN_WIDTH+1)'(1);
    end

    // Per-ID increment/decrement requests for the response debt counters
    always_comb begin
        pend_inc = '0;
        pend_dec = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            pend_inc[i] = burst_end & (head_id == ID_WIDTH'(i));
            pend_dec[i] = b_hs & (BID == ID_WIDTH'(i)) & (pending[i] != '0);
        end
    end

    // Response debt per ID: completed W bursts still awaiting their B
    always_ff @(posedge AWCLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_IDS; i++) pending[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                if (pend_inc[i] & ~pend_dec[i] & (pending[i] != CNT_W'(MAX_OUTSTANDING)))
                    pending[i] <= pending[i] + CNT_W'(1);
                else if (pend_dec[i] & ~pend_inc[i])
                    pending[i] <= pending[i] - CNT_W'(1);
            end
        end
    end

    // Data path and upper address bits carry nothing the checker needs
    assign unused_sig = ^{WDATA, WSTRB, BRESP, AWADDR[ADDR_WIDTH-1:12]};

endmodule
